// File: rtl/ibex_counter_bank.sv
// Machine counter bank: mcycle, minstret and NumHpm mhpmcounters with event selectors,
// mcountinhibit, debug freeze, per-counter overflow pulses and a synchronous CSR write port.
module ibex_counter_bank #(
    parameter int unsigned NumHpm       = 8,
    parameter int unsigned CounterWidth = 64,
    parameter int unsigned NumEvents    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NumEvents-1:0] event_i,
    input  logic                 freeze_i,
    input  logic [11:0]          csr_addr_i,
    input  logic                 csr_we_i,
    input  logic [31:0]          csr_wdata_i,
    output logic [31:0]          csr_rdata_o,
    output logic                 csr_hit_o,
    output logic [NumHpm+1:0]    overflow_o
);

    localparam int unsigned NumCnt     = NumHpm + 2;
    localparam int unsigned NumEvtRegs = (NumHpm > 0) ? NumHpm : 1;

    // Counter c lives at address offset 0 (mcycle), 2 (minstret) or c+1 (mhpmcounter);
    // the same offset is its bit position in mcountinhibit.
    function automatic logic [4:0] cnt_offset(input int c);
        return (c == 0) ? 5'd0 : 5'(c + 1);
    endfunction

    function automatic logic [31:0] inhibit_mask_f();
        logic [31:0] m;
        m = '0;
        for (int c = 0; c < int'(NumCnt); c++) m[cnt_offset(c)] = 1'b1;
        return m;
    endfunction

    localparam logic [31:0] InhibitMask = inhibit_mask_f();

    function automatic logic [63:0] zext_cnt(input logic [CounterWidth-1:0] v);
        logic [63:0] r;
        r = '0;
        r[CounterWidth-1:0] = v;
        return r;
    endfunction

    function automatic logic [31:0] zext_evt(input logic [NumEvents-1:0] v);
        logic [31:0] r;
        r = '0;
        r[NumEvents-1:0] = v;
        return r;
    endfunction

    logic [4:0] offset;
    logic       lo_range, hi_range, evt_range;

    assign offset    = csr_addr_i[4:0];
    assign lo_range  = (csr_addr_i[11:5] == 7'h58);  // 0xB00-0xB1F
    assign hi_range  = (csr_addr_i[11:5] == 7'h5C);  // 0xB80-0xB9F
    assign evt_range = (csr_addr_i[11:5] == 7'h19);  // 0x320-0x33F
    assign csr_hit_o = lo_range | hi_range | evt_range;

    logic [CounterWidth-1:0] cnt_val [NumCnt];
    logic [NumEvents-1:0]    evt_q   [NumEvtRegs];
    logic [31:0]             inhibit_q;

    // Event selectors and inhibit register.
    // NOTE: these are a handful of control registers, not a RAM, so every entry gets
    // a reset value; a bulk memory would normally be left unreset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inhibit_q <= '0;
            for (int k = 0; k < int'(NumEvtRegs); k++) evt_q[k] <= '0;
        end else if (csr_we_i && evt_range) begin
            if (offset == 5'd0) inhibit_q <= csr_wdata_i & InhibitMask;
            for (int k = 0; k < int'(NumHpm); k++) begin
                if (offset == 5'(k + 3)) evt_q[k] <= csr_wdata_i[NumEvents-1:0];
            end
        end
    end

    for (genvar g = 0; g < NumCnt; g++) begin : g_cnt
        logic                    sel, inc, wr_lo, wr_hi;
        logic [63:0]             wr_ext;
        logic [CounterWidth-1:0] value_q;
        logic                    overflow_q;

        if (g == 0) begin : g_sel_cycle
            assign sel = event_i[0];
        end else if (g == 1) begin : g_sel_instr
            assign sel = event_i[1];
        end else begin : g_sel_hpm
            assign sel = |(evt_q[g-2] & event_i);
        end

        assign inc   = sel & ~inhibit_q[cnt_offset(g)] & ~freeze_i;
        assign wr_lo = csr_we_i & lo_range & (offset == cnt_offset(g));
        assign wr_hi = csr_we_i & hi_range & (offset == cnt_offset(g));

        // Half-word write merges into the current value; bits above the width drop out.
        // NOTE: combinational block assigns a default first so no latch is inferred.
        always_comb begin
            wr_ext = zext_cnt(value_q);
            if (wr_lo) wr_ext[31:0]  = csr_wdata_i;
            if (wr_hi) wr_ext[63:32] = csr_wdata_i;
        end

        // NOTE: sequential state uses non-blocking assignment so all registers
        // update from the same pre-edge values.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                value_q    <= '0;
                overflow_q <= 1'b0;
            end else begin
                overflow_q <= 1'b0;
                if (wr_lo || wr_hi) begin
                    value_q <= wr_ext[CounterWidth-1:0];
                end else if (inc) begin
                    value_q    <= value_q + 1'b1;
                    overflow_q <= &value_q;
                end
            end
        end

        assign cnt_val[g]    = value_q;
        assign overflow_o[g] = overflow_q;
    end

    always_comb begin
        logic [63:0] ext;
        csr_rdata_o = '0;
        ext         = '0;
        if (lo_range || hi_range) begin
            for (int c = 0; c < int'(NumCnt); c++) begin
                if (offset == cnt_offset(c)) begin
                    ext         = zext_cnt(cnt_val[c]);
                    csr_rdata_o = hi_range ? ext[63:32] : ext[31:0];
                end
            end
        end else if (evt_range) begin
            if (offset == 5'd0) csr_rdata_o = inhibit_q;
            for (int k = 0; k < int'(NumHpm); k++) begin
                if (offset == 5'(k + 3)) csr_rdata_o = zext_evt(evt_q[k]);
            end
        end
    end

endmodule

// File: tb/tb_ibex_counter_bank.sv
// Directed bench for ibex_counter_bank at default parameters (NumHpm=8, 64-bit, 16 events).
module tb_ibex_counter_bank;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [15:0] event_i = '0;
    logic        freeze_i = 1'b0;
    logic [11:0] csr_addr_i = '0;
    logic        csr_we_i = 1'b0;
    logic [31:0] csr_wdata_i = '0;
    logic [31:0] csr_rdata_o;
    logic        csr_hit_o;
    logic [9:0]  overflow_o;

    int errors = 0;
    int checks = 0;

    ibex_counter_bank #(.NumHpm(8), .CounterWidth(64), .NumEvents(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .event_i(event_i), .freeze_i(freeze_i),
        .csr_addr_i(csr_addr_i), .csr_we_i(csr_we_i), .csr_wdata_i(csr_wdata_i),
        .csr_rdata_o(csr_rdata_o), .csr_hit_o(csr_hit_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change 1ns after the rising edge; outputs are sampled before the next edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        csr_addr_i = a;
        #1;
        d = csr_rdata_o;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_addr_i  = a;
        csr_wdata_i = d;
        csr_we_i    = 1'b1;
        step();
        csr_we_i    = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_i = 1'b1;
        step(2);
        rst_i = 1'b0;
        rd(12'hB00, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mcycle got=%h exp=%h", d, 32'h0); end
        rd(12'hB82, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_minstreth got=%h exp=%h", d, 32'h0); end
        checks++; if (overflow_o !== 10'h0) begin errors++; $display("FAIL reset_overflow got=%h exp=%h", overflow_o, 10'h0); end
    endtask

    task automatic test_count();
        logic [31:0] d;
        event_i = 16'h3;
        step(5);
        event_i = '0;
        rd(12'hB00, d);
        checks++; if (d !== 32'd5) begin errors++; $display("FAIL count_mcycle got=%0d exp=5", d); end
        rd(12'hB02, d);
        checks++; if (d !== 32'd5) begin errors++; $display("FAIL count_minstret got=%0d exp=5", d); end
        rd(12'hB03, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL count_hpm3_unmasked got=%0d exp=0", d); end
    endtask

    task automatic test_hpm();
        logic [31:0] d;
        wr(12'h323, 32'hFFFF_0004);
        rd(12'h323, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL hpm_event_readback got=%h exp=%h", d, 32'h4); end
        repeat (3) begin event_i = 16'h4; step(); event_i = '0; step(); end
        repeat (2) begin event_i = 16'h8; step(); event_i = '0; step(); end
        rd(12'hB03, d);
        checks++; if (d !== 32'd3) begin errors++; $display("FAIL hpm3_count got=%0d exp=3", d); end
        rd(12'hB00, d);
        checks++; if (d !== 32'd5) begin errors++; $display("FAIL hpm_mcycle_idle got=%0d exp=5", d); end
    endtask

    task automatic test_inhibit();
        logic [31:0] d;
        wr(12'h320, 32'hFFFF_FFFF);
        rd(12'h320, d);
        checks++; if (d !== 32'h0000_07FD) begin errors++; $display("FAIL inhibit_mask got=%h exp=%h", d, 32'h7FD); end
        wr(12'h320, 32'h0);
        // Event in the inhibit-write cycle still counts under the old (clear) inhibit.
        csr_addr_i = 12'h320; csr_wdata_i = 32'h1; csr_we_i = 1'b1; event_i = 16'h1;
        step();
        csr_we_i = 1'b0;
        step(4);
        event_i = '0;
        rd(12'hB00, d);
        checks++; if (d !== 32'd6) begin errors++; $display("FAIL inhibit_mcycle got=%0d exp=6", d); end
        wr(12'h320, 32'h0);
        freeze_i = 1'b1; event_i = 16'hF;
        step(3);
        freeze_i = 1'b0; event_i = '0;
        rd(12'hB00, d);
        checks++; if (d !== 32'd6) begin errors++; $display("FAIL freeze_mcycle got=%0d exp=6", d); end
        rd(12'hB02, d);
        checks++; if (d !== 32'd5) begin errors++; $display("FAIL freeze_minstret got=%0d exp=5", d); end
        rd(12'hB03, d);
        checks++; if (d !== 32'd3) begin errors++; $display("FAIL freeze_hpm3 got=%0d exp=3", d); end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        wr(12'hB80, 32'hFFFF_FFFF);
        wr(12'hB00, 32'hFFFF_FFFE);
        checks++; if (overflow_o !== 10'h0) begin errors++; $display("FAIL wrap_write_no_ovf got=%h exp=%h", overflow_o, 10'h0); end
        event_i = 16'h1;
        step();
        checks++; if (overflow_o !== 10'h0) begin errors++; $display("FAIL wrap_early_ovf got=%h exp=%h", overflow_o, 10'h0); end
        step();
        event_i = '0;
        checks++; if (overflow_o !== 10'h001) begin errors++; $display("FAIL wrap_ovf_pulse got=%h exp=%h", overflow_o, 10'h1); end
        rd(12'hB00, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL wrap_mcycle_lo got=%h exp=%h", d, 32'h0); end
        rd(12'hB80, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL wrap_mcycle_hi got=%h exp=%h", d, 32'h0); end
        step();
        checks++; if (overflow_o !== 10'h0) begin errors++; $display("FAIL wrap_ovf_one_cycle got=%h exp=%h", overflow_o, 10'h0); end
    endtask

    task automatic test_write_wins();
        logic [31:0] d;
        csr_addr_i = 12'hB02; csr_wdata_i = 32'h10; csr_we_i = 1'b1; event_i = 16'h2;
        step();
        csr_we_i = 1'b0; event_i = '0;
        rd(12'hB02, d);
        checks++; if (d !== 32'h10) begin errors++; $display("FAIL write_wins_lo got=%h exp=%h", d, 32'h10); end
        rd(12'hB82, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL write_wins_hi got=%h exp=%h", d, 32'h0); end
        event_i = 16'h2;
        step();
        event_i = '0;
        wr(12'hB82, 32'h7);
        rd(12'hB02, d);
        checks++; if (d !== 32'h11) begin errors++; $display("FAIL hi_write_keeps_lo got=%h exp=%h", d, 32'h11); end
        rd(12'hB82, d);
        checks++; if (d !== 32'h7) begin errors++; $display("FAIL hi_write got=%h exp=%h", d, 32'h7); end
    endtask

    task automatic test_unimpl();
        logic [31:0] d;
        wr(12'hB01, 32'h55);
        rd(12'hB01, d);
        checks++; if (d !== 32'h0 || csr_hit_o !== 1'b1) begin errors++; $display("FAIL unimpl_b01 got=%h/%b exp=0/1", d, csr_hit_o); end
        rd(12'h321, d);
        checks++; if (d !== 32'h0 || csr_hit_o !== 1'b1) begin errors++; $display("FAIL unimpl_321 got=%h/%b exp=0/1", d, csr_hit_o); end
        rd(12'hB0F, d);
        checks++; if (d !== 32'h0 || csr_hit_o !== 1'b1) begin errors++; $display("FAIL unimpl_b0f got=%h/%b exp=0/1", d, csr_hit_o); end
        rd(12'hB00, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unimpl_write_leak got=%h exp=%h", d, 32'h0); end
        rd(12'h300, d);
        checks++; if (csr_hit_o !== 1'b0) begin errors++; $display("FAIL miss_300 got=%b exp=0", csr_hit_o); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        wr(12'h320, 32'h0);
        event_i = 16'h7;
        step(3);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        rd(12'hB00, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_mcycle got=%h exp=%h", d, 32'h0); end
        rd(12'hB02, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_minstret got=%h exp=%h", d, 32'h0); end
        rd(12'hB03, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_hpm3 got=%h exp=%h", d, 32'h0); end
        rd(12'h323, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_event3 got=%h exp=%h", d, 32'h0); end
        event_i = '0;
    endtask

    initial begin
        step();
        test_reset();
        test_count();
        test_hpm();
        test_inhibit();
        test_wrap();
        test_write_wins();
        test_unimpl();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
